// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO family.
package fifo_pkg;

   // Read-mode selectors for the FWFT parameter
   localparam int FIFO_STD  = 0;
   localparam int FIFO_FWFT = 1;

   // Address width needed to index a RAM of the given depth (at least one bit)
   function automatic int fifo_addr_w(input int depth);
      if (depth > 1) begin
         return $clog2(depth);
      end else begin
         return 1;
      end
   endfunction

endpackage

// File: rtl/sync_dualport_ram.sv
// Simple dual-port RAM, one write and one read port on the same clock.
// RD_REG=1 gives a registered read that clears on rst/clr; RD_REG=0 reads combinationally.
module sync_dualport_ram #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int RD_REG     = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   localparam int RAM_DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [0:RAM_DEPTH-1];

   // Storage array: written on qualified write strobe, never reset
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   generate
      if (RD_REG != 0) begin : g_reg_rd
         logic [DATA_WIDTH-1:0] rdata_q;

         // Registered read port: loads on re, holds otherwise, cleared by rst/clr
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               rdata_q <= '0;
            end else if (clr) begin
               rdata_q <= '0;
            end else if (re) begin
               rdata_q <= mem_q[raddr];
            end
         end

         assign rdata = rdata_q;
      end else begin : g_comb_rd
         logic unused_ctrl_s;

         assign unused_ctrl_s = ^{rst, clr, re};
         assign rdata         = mem_q[raddr];
      end
   endgenerate

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock parametrised FIFO with occupancy count, programmable almost
// thresholds, sticky overflow/underflow flags, synchronous flush and a
// selectable standard or first-word-fall-through read mode.
module sync_fifo_flex
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int FIFO_DEPTH  = 16,
   parameter int FIFO_AFULL  = FIFO_DEPTH - 1,
   parameter int FIFO_AEMPTY = 1,
   parameter int FWFT        = 0
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              clr,
   input  logic                              wr_en,
   input  logic [DATA_WIDTH-1:0]             wr_data,
   input  logic                              rd_en,
   output logic [DATA_WIDTH-1:0]             rd_data,
   output logic                              rd_valid,
   output logic [fifo_addr_w(FIFO_DEPTH):0]  count,
   output logic                              full,
   output logic                              empty,
   output logic                              afull,
   output logic                              aempty,
   output logic                              overflow,
   output logic                              underflow
);

   localparam int AW = fifo_addr_w(FIFO_DEPTH);
   localparam int CW = AW + 1;

   localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] AFULL_C  = CW'(FIFO_AFULL);
   localparam logic [CW-1:0] AEMPTY_C = CW'(FIFO_AEMPTY);
   // With count at zero, afull only holds if its threshold is zero
   localparam logic          AFULL_RST_C = (FIFO_AFULL == 0) ? 1'b1 : 1'b0;

   logic [CW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  full_q, full_d;
   logic                  empty_q, empty_d;
   logic                  afull_q, afull_d;
   logic                  aempty_q, aempty_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic                  rd_valid_q, rd_valid_d;
   logic                  wr_vld_s, rd_vld_s;
   logic                  ram_we_s, ram_re_s;
   logic [DATA_WIDTH-1:0] ram_rdata_s;
   logic [DATA_WIDTH-1:0] rd_data_s;

   // Qualified strobes and next-state for pointers, count, flags and stickies
   always_comb begin
      wr_vld_s    = wr_en & ~full_q;
      rd_vld_s    = rd_en & ~empty_q;
      wr_ptr_d    = wr_ptr_q + CW'(wr_vld_s);
      rd_ptr_d    = rd_ptr_q + CW'(rd_vld_s);
      count_d     = count_q + CW'(wr_vld_s) - CW'(rd_vld_s);
      full_d      = (count_d == DEPTH_C);
      empty_d     = (count_d == {CW{1'b0}});
      afull_d     = (count_d >= AFULL_C);
      aempty_d    = (count_d <= AEMPTY_C);
      overflow_d  = overflow_q | (wr_en & full_q);
      underflow_d = underflow_q | (rd_en & empty_q);
      rd_valid_d  = rd_vld_s;
      // A flush wins over both strobes, so neither touches the RAM that cycle
      ram_we_s    = wr_vld_s & ~clr;
      ram_re_s    = rd_vld_s & ~clr;
   end

   // Pointer, count and flag registers with async reset and synchronous flush
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         afull_q     <= AFULL_RST_C;
         aempty_q    <= 1'b1;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         rd_valid_q  <= 1'b0;
      end else if (clr) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         afull_q     <= AFULL_RST_C;
         aempty_q    <= 1'b1;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         rd_valid_q  <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         full_q      <= full_d;
         empty_q     <= empty_d;
         afull_q     <= afull_d;
         aempty_q    <= aempty_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         rd_valid_q  <= rd_valid_d;
      end
   end

   sync_dualport_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (AW),
      .RD_REG     ((FWFT == FIFO_FWFT) ? 0 : 1)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .we    (ram_we_s),
      .waddr (wr_ptr_q[AW-1:0]),
      .wdata (wr_data),
      .re    (ram_re_s),
      .raddr (rd_ptr_q[AW-1:0]),
      .rdata (ram_rdata_s)
   );

   // Read data: FWFT shows the head word only while non-empty, so reset/flush read as zero
   always_comb begin
      rd_data_s = ram_rdata_s;
      if (FWFT == FIFO_FWFT) begin
         if (empty_q) begin
            rd_data_s = '0;
         end else begin
            rd_data_s = ram_rdata_s;
         end
      end else begin
         rd_data_s = ram_rdata_s;
      end
   end

   assign rd_data   = rd_data_s;
   assign rd_valid  = (FWFT == FIFO_FWFT) ? ~empty_q : rd_valid_q;
   assign count     = count_q;
   assign full      = full_q;
   assign empty     = empty_q;
   assign afull     = afull_q;
   assign aempty    = aempty_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Scoreboard bench for sync_fifo_flex: a standard-read instance checked through
// an expected-data queue and monitor, plus an FWFT instance checked directly.
module tb_sync_fifo_flex;

   logic       clk = 1'b0;
   logic       rst;
   logic       clr, wr_en, rd_en;
   logic [7:0] wr_data, rd_data;
   logic       rd_valid, full, empty, afull, aempty, overflow, underflow;
   logic [4:0] count;

   logic       f_clr, f_wr_en, f_rd_en;
   logic [7:0] f_wr_data, f_rd_data;
   logic       f_rd_valid, f_full, f_empty, f_afull, f_aempty, f_overflow, f_underflow;
   logic [4:0] f_count;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   sync_fifo_flex #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .FIFO_AFULL(15), .FIFO_AEMPTY(1), .FWFT(0)) dut (
      .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .rd_data(rd_data), .rd_valid(rd_valid), .count(count), .full(full), .empty(empty),
      .afull(afull), .aempty(aempty), .overflow(overflow), .underflow(underflow)
   );

   sync_fifo_flex #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .FIFO_AFULL(15), .FIFO_AEMPTY(1), .FWFT(1)) dut_fwft (
      .clk(clk), .rst(rst), .clr(f_clr), .wr_en(f_wr_en), .wr_data(f_wr_data), .rd_en(f_rd_en),
      .rd_data(f_rd_data), .rd_valid(f_rd_valid), .count(f_count), .full(f_full), .empty(f_empty),
      .afull(f_afull), .aempty(f_aempty), .overflow(f_overflow), .underflow(f_underflow)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every rd_valid pulse must match the oldest expected word
   always @(negedge clk) begin
      logic [7:0] e;
      if (rd_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rd_unexpected actual=%0h required=none", rd_data);
         end else begin
            e = exp_q.pop_front();
            chk("rd_data", {24'd0, rd_data}, {24'd0, e});
         end
      end
   end

   initial begin
      rst = 1'b1; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
      f_clr = 1'b0; f_wr_en = 1'b0; f_rd_en = 1'b0; f_wr_data = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_empty", empty, 1);
      chk("rst_aempty", aempty, 1);
      chk("rst_full", full, 0);
      chk("rst_afull", afull, 0);
      chk("rst_count", count, 0);
      chk("rst_ovf_unf", {overflow, underflow}, 0);
      chk("rst_rd_valid", rd_valid, 0);
      rst = 1'b0;

      // fill 0x00..0x0F
      for (int i = 0; i < 16; i++) begin
         wr_en = 1'b1; wr_data = 8'(i);
         tick();
         chk("fill_count", count, i + 1);
         chk("fill_afull", afull, (i + 1 >= 15));
         chk("fill_full", full, (i + 1 == 16));
         chk("fill_empty", empty, 0);
      end
      wr_data = 8'h77;
      tick();
      wr_en = 1'b0;
      chk("ovf_count", count, 16);
      chk("ovf_full", full, 1);
      chk("ovf_flag", overflow, 1);

      // drain, expecting 0x00..0x0F in order
      for (int i = 0; i < 16; i++) begin
         rd_en = 1'b1;
         exp_q.push_back(8'(i));
         tick();
         chk("drain_count", count, 15 - i);
         chk("drain_aempty", aempty, (15 - i <= 1));
         chk("drain_empty", empty, (i == 15));
         chk("drain_full", full, 0);
      end
      tick();
      rd_en = 1'b0;
      chk("unf_flag", underflow, 1);
      chk("unf_hold_data", rd_data, 8'h0F);
      chk("ovf_sticky", overflow, 1);

      // asynchronous reset mid-run, observed before the next clock edge
      #2;
      rst = 1'b1;
      #1;
      chk("arst_ovf_unf", {overflow, underflow}, 0);
      chk("arst_flags", {full, empty, afull, aempty}, 4'b0101);
      chk("arst_count", count, 0);
      chk("arst_rd", {rd_valid, rd_data}, 0);
      tick();
      rst = 1'b0;

      // wrap: hold count at 8 with simultaneous read/write for 40 cycles
      for (int i = 0; i < 8; i++) begin
         wr_en = 1'b1; wr_data = 8'(8'h80 + i);
         tick();
      end
      chk("wrap_pre_count", count, 8);
      for (int k = 0; k < 40; k++) begin
         wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'(8'h90 + k);
         exp_q.push_back((k < 8) ? 8'(8'h80 + k) : 8'(8'h90 + k - 8));
         tick();
         chk("wrap_count", count, 8);
         chk("wrap_flags", {full, empty, afull, aempty}, 4'b0000);
      end
      wr_en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         rd_en = 1'b1;
         exp_q.push_back(8'(8'hB0 + i));
         tick();
      end
      rd_en = 1'b0;
      chk("wrap_end_count", count, 0);
      chk("wrap_end_empty", empty, 1);

      // flush with wr_en and rd_en also asserted
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk("flush_pre_unf", underflow, 1);
      for (int i = 0; i < 10; i++) begin
         wr_en = 1'b1; wr_data = 8'(8'hC0 + i);
         tick();
      end
      chk("flush_pre_count", count, 10);
      clr = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hEE;
      tick();
      clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
      chk("flush_count", count, 0);
      chk("flush_flags", {full, empty, afull, aempty}, 4'b0101);
      chk("flush_sticky", {overflow, underflow}, 0);
      chk("flush_rd_data", rd_data, 0);
      wr_en = 1'b1; wr_data = 8'hD1;
      tick();
      wr_en = 1'b0;
      chk("post_flush_count", count, 1);
      rd_en = 1'b1;
      exp_q.push_back(8'hD1);
      tick();
      rd_en = 1'b0;
      tick();

      // FWFT instance
      chk("fwft_idle", {f_empty, f_rd_valid}, 2'b10);
      f_wr_en = 1'b1; f_wr_data = 8'hA5;
      tick();
      f_wr_en = 1'b0;
      chk("fwft_empty", f_empty, 0);
      chk("fwft_valid", f_rd_valid, 1);
      chk("fwft_data", f_rd_data, 8'hA5);
      chk("fwft_count", f_count, 1);
      f_rd_en = 1'b1;
      tick();
      f_rd_en = 1'b0;
      chk("fwft_pop_empty", f_empty, 1);
      chk("fwft_pop_valid", f_rd_valid, 0);

      repeat (2) tick();
      chk("sb_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
